// File: rtl/chunked_alu_pkg.sv
// Shared types for the chunked ALU: opcode and FSM state encodings.
package chunked_alu_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_XOR = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/chunked_alu_chunk_slice.sv
// Combinational CHUNK-bit slice: add/subtract with carry, or bitwise AND/XOR.
module chunk_slice
  import chunked_alu_pkg::*;
#(
  parameter int CHUNK = 2
) (
  input  logic [CHUNK-1:0] a_k_i,
  input  logic [CHUNK-1:0] b_k_i,
  input  logic             carry_i,
  input  op_e              op_i,
  output logic [CHUNK-1:0] res_o,
  output logic             carry_o
);

  logic [CHUNK-1:0] b_eff;
  logic [CHUNK:0]   sum;

  // Subtraction is a + ~b + carry, with the carry seeded to 1 by the caller.
  always_comb begin
    b_eff = (op_i == OP_SUB) ? ~b_k_i : b_k_i;
    sum   = {1'b0, a_k_i} + {1'b0, b_eff} + {{CHUNK{1'b0}}, carry_i};
    unique case (op_i)
      OP_AND: begin
        res_o   = a_k_i & b_k_i;
        carry_o = 1'b0;
      end
      OP_XOR: begin
        res_o   = a_k_i ^ b_k_i;
        carry_o = 1'b0;
      end
      default: begin
        res_o   = sum[CHUNK-1:0];
        carry_o = sum[CHUNK];
      end
    endcase
  end

endmodule

// File: rtl/chunked_alu.sv
// Multi-cycle ALU evaluating CHUNK bits per cycle with a registered carry.
// Optional accumulator operand enabled by defining CHUNKED_ALU_ACC_EN.
module chunked_alu
  import chunked_alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [1:0]       op_i,
  input  logic             acc_sel_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic             cout_o
);

  localparam int NSLICE = WIDTH / CHUNK;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

  state_e           state_q;
  op_e              op_q;
  logic [WIDTH-1:0] a_q, b_q, result_q;
  logic [CW-1:0]    cnt_q;
  logic             carry_q, cout_q, out_valid_q, in_ready_q;

  logic [WIDTH-1:0] opa_d;
  logic [CHUNK-1:0] slice_a_d, slice_b_d, slice_res_d;
  logic             slice_carry_d;
  op_e              op_in_d;

`ifdef CHUNKED_ALU_ACC_EN
  assign opa_d = acc_sel_i ? result_q : a_i;
`else
  logic unused_acc_sel;
  assign unused_acc_sel = acc_sel_i;
  assign opa_d          = a_i;
`endif

  assign op_in_d   = op_e'(op_i);
  assign slice_a_d = a_q[int'(cnt_q)*CHUNK +: CHUNK];
  assign slice_b_d = b_q[int'(cnt_q)*CHUNK +: CHUNK];

  chunk_slice #(.CHUNK(CHUNK)) u_slice (
    .a_k_i   (slice_a_d),
    .b_k_i   (slice_b_d),
    .carry_i (carry_q),
    .op_i    (op_q),
    .res_o   (slice_res_d),
    .carry_o (slice_carry_d)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      op_q        <= OP_ADD;
      a_q         <= '0;
      b_q         <= '0;
      result_q    <= '0;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      cout_q      <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (in_valid_i) begin
            a_q        <= opa_d;
            b_q        <= b_i;
            op_q       <= op_in_d;
            cnt_q      <= '0;
            carry_q    <= (op_in_d == OP_SUB);
            in_ready_q <= 1'b0;
            state_q    <= S_RUN;
          end
        end
        S_RUN: begin
          result_q[int'(cnt_q)*CHUNK +: CHUNK] <= slice_res_d;
          carry_q <= slice_carry_d;
          cnt_q   <= cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            cout_q      <= slice_carry_d;
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready_i) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign result_o    = result_q;
  assign cout_o      = cout_q;

endmodule

// File: tb/tb_chunked_alu.sv
// Scoreboard bench for chunked_alu: directed vectors, results checked by a monitor.
module tb_chunked_alu;
  import chunked_alu_pkg::*;

  logic       clk, rst, in_valid, in_ready, acc_sel, out_valid, out_ready, cout;
  logic [7:0] a, b, result;
  logic [1:0] op;

  typedef struct {
    logic [7:0] res;
    logic       c;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  chunked_alu #(.WIDTH(8), .CHUNK(2)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .a_i         (a),
    .b_i         (b),
    .op_i        (op),
    .acc_sel_i   (acc_sel),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .result_o    (result),
    .cout_o      (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every output handshake.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_output: got result 0x%0h with empty scoreboard", result);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check({e.name, " result"}, 32'(result), 32'(e.res));
        check({e.name, " cout"}, 32'(cout), 32'(e.c));
      end
    end
  end

  task automatic issue(input string nm, input logic [1:0] o, input logic [7:0] va,
                       input logic [7:0] vb, input logic acc, input logic [7:0] er,
                       input logic ec, input logic push);
    int w = 0;
    exp_t e;
    while (!in_ready && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    check({nm, " in_ready_before_accept"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1; op = o; a = va; b = vb; acc_sel = acc;
    @(posedge clk); #1;
    in_valid = 1'b0; acc_sel = 1'b0;
    if (push) begin
      e.res = er; e.c = ec; e.name = nm;
      sb.push_back(e);
    end
    check({nm, " in_ready_after_accept"}, 32'(in_ready), 32'd0);
  endtask

  task automatic wait_done(input string nm);
    int   lat = 0;
    logic rdy_seen = 1'b0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (in_ready) rdy_seen = 1'b1;
    end
    check({nm, " latency"}, 32'(lat), 32'd4);
    check({nm, " in_ready_during_run"}, 32'(rdy_seen), 32'd0);
  endtask

  task automatic run_op(input string nm, input logic [1:0] o, input logic [7:0] va,
                        input logic [7:0] vb, input logic acc, input logic [7:0] er,
                        input logic ec);
    issue(nm, o, va, vb, acc, er, ec, 1'b1);
    wait_done(nm);
    @(posedge clk); #1;
    check({nm, " out_valid_one_cycle"}, 32'(out_valid), 32'd0);
    check({nm, " in_ready_back"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; acc_sel = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; op = 2'b00;
    #12;
    check("reset result", 32'(result), 32'd0);
    check("reset cout", 32'(cout), 32'd0);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;

    run_op("add_ff_01",  2'b00, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    run_op("sub_05_07",  2'b01, 8'h05, 8'h07, 1'b0, 8'hFE, 1'b0);
    run_op("sub_07_05",  2'b01, 8'h07, 8'h05, 1'b0, 8'h02, 1'b1);
    run_op("sub_3c_3c",  2'b01, 8'h3C, 8'h3C, 1'b0, 8'h00, 1'b1);
    run_op("and_f0_3c",  2'b10, 8'hF0, 8'h3C, 1'b0, 8'h30, 1'b0);
    run_op("xor_f0_3c",  2'b11, 8'hF0, 8'h3C, 1'b0, 8'hCC, 1'b0);
    run_op("add_a5_5b",  2'b00, 8'hA5, 8'h5B, 1'b0, 8'h00, 1'b1);

    // Back-pressure: DONE held while stray requests arrive.
    out_ready = 1'b0;
    issue("bp_add_0f_01", 2'b00, 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b1);
    wait_done("bp_add_0f_01");
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; a = 8'h11; b = 8'h11; op = 2'b00;
      @(posedge clk); #1;
      check("bp out_valid_held", 32'(out_valid), 32'd1);
      check("bp result_held", 32'(result), 32'h10);
      check("bp cout_held", 32'(cout), 32'd0);
      check("bp no_accept", 32'(in_ready), 32'd0);
    end
    begin
      exp_t e;
      e.res = 8'h33; e.c = 1'b0; e.name = "bp_next_add";
      sb.push_back(e);
    end
    b = 8'h22;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp release in_ready", 32'(in_ready), 32'd1);
    check("bp release out_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp next accept", 32'(in_ready), 32'd0);
    wait_done("bp_next_add");
    @(posedge clk); #1;

    // Reset during RUN slice 2 of 0x12+0x34; the operation is dropped.
    issue("rst_add_12_34", 2'b00, 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("midrun_rst result", 32'(result), 32'd0);
    check("midrun_rst cout", 32'(cout), 32'd0);
    check("midrun_rst out_valid", 32'(out_valid), 32'd0);
    check("midrun_rst in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    run_op("add_10_20", 2'b00, 8'h10, 8'h20, 1'b0, 8'h30, 1'b0);
`ifdef CHUNKED_ALU_ACC_EN
    run_op("acc_add", 2'b00, 8'h99, 8'h05, 1'b1, 8'h35, 1'b0);
`else
    run_op("acc_add", 2'b00, 8'h99, 8'h05, 1'b1, 8'h9E, 1'b0);
`endif

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
